// File: rtl/alu_writeback.sv
// Writeback stage behind a fixed-latency ALU: tag tracking, in-order result buffer, credit-throttled issue.
// Optional forwarding outputs are enabled by defining ALU_WB_BYPASS_EN.
module alu_writeback #(
  parameter int ADDR_W    = 11,
  parameter int LATENCY   = 3,
  parameter int BUF_DEPTH = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_issue_valid,
  output logic              io_issue_ready,
  input  logic [ADDR_W-1:0] io_issue_rd,
  input  logic [3:0]        io_issue_funct,
  input  logic              io_issue_carry_wr,
  input  logic [15:0]       io_alu_out,
  input  logic [31:0]       io_alu_mul_out,
  input  logic              io_alu_carry_out,
  output logic              io_rf_wen,
  output logic [ADDR_W-1:0] io_rf_waddr,
  output logic [15:0]       io_rf_wdata,
  output logic              io_rf_carry_wen,
  output logic              io_rf_carry,
  input  logic              io_rf_grant,
  input  logic [ADDR_W-1:0] io_query_rs,
  output logic              io_query_hit,
  output logic              io_empty,
`ifdef ALU_WB_BYPASS_EN
  output logic              io_byp_valid,
  output logic [ADDR_W-1:0] io_byp_rd,
  output logic [15:0]       io_byp_data,
`endif
  output logic              io_overflow
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + LATENCY + 1);
  localparam logic [3:0]       FUNCT_MULH = 4'd3;
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(BUF_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_next = {PTR_W{1'b0}};
    end else begin
      ptr_next = p + PTR_W'(1'b1);
    end
  endfunction

  logic [LATENCY-1:0] tag_valid_r;
  logic [ADDR_W-1:0]  tag_rd_r   [LATENCY];
  logic               tag_mulh_r [LATENCY];
  logic               tag_cwr_r  [LATENCY];

  logic [ADDR_W-1:0]  buf_rd_r    [BUF_DEPTH];
  logic [15:0]        buf_data_r  [BUF_DEPTH];
  logic               buf_cwen_r  [BUF_DEPTH];
  logic               buf_carry_r [BUF_DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CNT_W-1:0]   count_r;
  logic               overflow_r;

  logic               accept_s;
  logic               cap_s;
  logic               pop_s;
  logic               has_head_s;
  logic [15:0]        cap_data_s;
  logic [15:0]        mul_hi_s;
  logic [15:0]        mul_lo_unused_s;
  logic [CNT_W-1:0]   tag_cnt_s;
  logic [CNT_W-1:0]   credits_s;
  logic               hit_s;

  assign {mul_hi_s, mul_lo_unused_s} = io_alu_mul_out;

  assign accept_s   = io_issue_valid & io_issue_ready;
  assign cap_s      = tag_valid_r[LATENCY-1];
  assign cap_data_s = tag_mulh_r[LATENCY-1] ? mul_hi_s : io_alu_out;
  assign has_head_s = (count_r != {CNT_W{1'b0}});
  assign pop_s      = has_head_s & io_rf_grant;

  // Credits come only from registered state so a same-cycle pop never frees one.
  always_comb begin
    tag_cnt_s = {CNT_W{1'b0}};
    for (int i = 0; i < LATENCY; i++) begin
      tag_cnt_s = tag_cnt_s + CNT_W'(tag_valid_r[i]);
    end
    credits_s = tag_cnt_s + count_r;
  end

  assign io_issue_ready = (credits_s < CNT_W'(BUF_DEPTH));
  assign io_empty       = (tag_valid_r == {LATENCY{1'b0}}) && !has_head_s;
  assign io_overflow    = overflow_r;

  // Valid bits of the tag pipeline, aligned with the ALU latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_valid_r <= {LATENCY{1'b0}};
    end else begin
      tag_valid_r[0] <= accept_s;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
      end
    end
  end

  // Tag payload shifts freely; it is only looked at where the matching valid is set.
  always_ff @(posedge clock) begin
    tag_rd_r[0]   <= io_issue_rd;
    tag_mulh_r[0] <= (io_issue_funct == FUNCT_MULH);
    tag_cwr_r[0]  <= io_issue_carry_wr;
    for (int i = 1; i < LATENCY; i++) begin
      tag_rd_r[i]   <= tag_rd_r[i-1];
      tag_mulh_r[i] <= tag_mulh_r[i-1];
      tag_cwr_r[i]  <= tag_cwr_r[i-1];
    end
  end

  // Result storage written at the tail when the oldest tag emerges from the ALU.
  always_ff @(posedge clock) begin
    if (cap_s) begin
      buf_rd_r[tail_r]    <= tag_rd_r[LATENCY-1];
      buf_data_r[tail_r]  <= cap_data_s;
      buf_cwen_r[tail_r]  <= tag_cwr_r[LATENCY-1];
      buf_carry_r[tail_r] <= io_alu_carry_out;
    end
  end

  // Buffer pointers and occupancy; occupancy disambiguates full from empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (cap_s) begin
        tail_r <= ptr_next(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_next(head_r);
      end
      case ({cap_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky record of an issue attempted without a credit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | (io_issue_valid & ~io_issue_ready);
    end
  end

  // Head entry drives the register-file port; zeros when nothing is buffered.
  always_comb begin
    io_rf_wen = has_head_s;
    if (has_head_s) begin
      io_rf_waddr     = buf_rd_r[head_r];
      io_rf_wdata     = buf_data_r[head_r];
      io_rf_carry_wen = buf_cwen_r[head_r];
      io_rf_carry     = buf_carry_r[head_r];
    end else begin
      io_rf_waddr     = {ADDR_W{1'b0}};
      io_rf_wdata     = 16'h0000;
      io_rf_carry_wen = 1'b0;
      io_rf_carry     = 1'b0;
    end
  end

  // Hazard match over live tag stages and live buffer slots (slot live if its distance from head < count).
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      hit_s = hit_s | (tag_valid_r[i] & (tag_rd_r[i] == io_query_rs));
    end
    for (int i = 0; i < BUF_DEPTH; i++) begin
      hit_s = hit_s |
              ((((i >= int'(head_r)) ? (i - int'(head_r)) : (i + BUF_DEPTH - int'(head_r))) < int'(count_r)) &
               (buf_rd_r[i] == io_query_rs));
    end
  end

  assign io_query_hit = hit_s;

`ifdef ALU_WB_BYPASS_EN
  assign io_byp_valid = cap_s;
  assign io_byp_rd    = tag_rd_r[LATENCY-1];
  assign io_byp_data  = cap_data_s;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table, transaction-level model with random stimulus,
// and hand-written backpressure / violation / mid-operation reset sequences.
module tb_alu_writeback;

  localparam int LAT = 3;
  localparam int BUF = 6;

  logic        clock;
  logic        reset;
  logic        io_issue_valid;
  logic        io_issue_ready;
  logic [10:0] io_issue_rd;
  logic [3:0]  io_issue_funct;
  logic        io_issue_carry_wr;
  logic [15:0] io_alu_out;
  logic [31:0] io_alu_mul_out;
  logic        io_alu_carry_out;
  logic        io_rf_wen;
  logic [10:0] io_rf_waddr;
  logic [15:0] io_rf_wdata;
  logic        io_rf_carry_wen;
  logic        io_rf_carry;
  logic        io_rf_grant;
  logic [10:0] io_query_rs;
  logic        io_query_hit;
  logic        io_empty;
  logic        io_overflow;
`ifdef ALU_WB_BYPASS_EN
  logic        io_byp_valid;
  logic [10:0] io_byp_rd;
  logic [15:0] io_byp_data;
`endif

  alu_writeback #(.ADDR_W(11), .LATENCY(LAT), .BUF_DEPTH(BUF)) dut (
    .clock(clock), .reset(reset),
    .io_issue_valid(io_issue_valid), .io_issue_ready(io_issue_ready),
    .io_issue_rd(io_issue_rd), .io_issue_funct(io_issue_funct), .io_issue_carry_wr(io_issue_carry_wr),
    .io_alu_out(io_alu_out), .io_alu_mul_out(io_alu_mul_out), .io_alu_carry_out(io_alu_carry_out),
    .io_rf_wen(io_rf_wen), .io_rf_waddr(io_rf_waddr), .io_rf_wdata(io_rf_wdata),
    .io_rf_carry_wen(io_rf_carry_wen), .io_rf_carry(io_rf_carry), .io_rf_grant(io_rf_grant),
    .io_query_rs(io_query_rs), .io_query_hit(io_query_hit), .io_empty(io_empty),
`ifdef ALU_WB_BYPASS_EN
    .io_byp_valid(io_byp_valid), .io_byp_rd(io_byp_rd), .io_byp_data(io_byp_data),
`endif
    .io_overflow(io_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queues of in-flight ops and buffered results
  typedef struct { logic [10:0] rd; logic [3:0] f; logic cw; int born; } tag_t;
  typedef struct { logic [10:0] rd; logic [15:0] data; logic cw; logic c; } ent_t;
  tag_t infl[$];
  ent_t fifo[$];
  logic m_ovf;
  int   cyc;
  int   wr_cnt;
  int   acc_cnt;
  logic [10:0] wr_addrs[$];

  function automatic logic m_ready();
    return (infl.size() + fifo.size()) < BUF;
  endfunction

  task automatic drive(input logic v, input logic [10:0] rd, input logic [3:0] f, input logic cw,
                       input logic [15:0] alu, input logic [31:0] mul, input logic c,
                       input logic g, input logic [10:0] rs);
    @(negedge clock);
    io_issue_valid    = v;
    io_issue_rd       = rd;
    io_issue_funct    = f;
    io_issue_carry_wr = cw;
    io_alu_out        = alu;
    io_alu_mul_out    = mul;
    io_alu_carry_out  = c;
    io_rf_grant       = g;
    io_query_rs       = rs;
    #1;
  endtask

  task automatic step(input logic v, input logic [10:0] rd, input logic [3:0] f, input logic cw,
                      input logic g, input logic [10:0] rs);
    logic [15:0] alu;
    logic [31:0] mul;
    logic        c;
    logic        e_ready, e_wen, e_cwen, e_carry, e_hit, e_empty;
    logic [10:0] e_waddr;
    logic [15:0] e_wdata;
    tag_t        t;
    ent_t        en;
    alu = 16'($urandom);
    mul = $urandom;
    c   = 1'($urandom_range(0, 1));
    drive(v, rd, f, cw, alu, mul, c, g, rs);
    e_ready = m_ready();
    e_wen   = (fifo.size() > 0);
    e_waddr = e_wen ? fifo[0].rd   : 11'd0;
    e_wdata = e_wen ? fifo[0].data : 16'h0000;
    e_cwen  = e_wen ? fifo[0].cw   : 1'b0;
    e_carry = e_wen ? fifo[0].c    : 1'b0;
    e_empty = (fifo.size() == 0) && (infl.size() == 0);
    e_hit   = 1'b0;
    foreach (infl[i]) if (infl[i].rd == rs) e_hit = 1'b1;
    foreach (fifo[i]) if (fifo[i].rd == rs) e_hit = 1'b1;
    chk("ready", 32'(io_issue_ready), 32'(e_ready));
    chk("wen", 32'(io_rf_wen), 32'(e_wen));
    chk("waddr", 32'(io_rf_waddr), 32'(e_waddr));
    chk("wdata", 32'(io_rf_wdata), 32'(e_wdata));
    chk("carry_wen", 32'(io_rf_carry_wen), 32'(e_cwen));
    chk("carry", 32'(io_rf_carry), 32'(e_carry));
    chk("hit", 32'(io_query_hit), 32'(e_hit));
    chk("empty", 32'(io_empty), 32'(e_empty));
    chk("overflow", 32'(io_overflow), 32'(m_ovf));
    if (io_rf_wen && g) begin
      wr_cnt++;
      wr_addrs.push_back(io_rf_waddr);
    end
    if (v && io_issue_ready) acc_cnt++;
    // advance the model across the coming clock edge
    if (fifo.size() > 0 && g) en = fifo.pop_front();
    if (infl.size() > 0 && infl[0].born == cyc - LAT) begin
      t       = infl.pop_front();
      en.rd   = t.rd;
      en.data = (t.f == 4'd3) ? mul[31:16] : alu;
      en.cw   = t.cw;
      en.c    = c;
      fifo.push_back(en);
    end
    if (v) begin
      if (e_ready) begin
        t.rd = rd; t.f = f; t.cw = cw; t.born = cyc;
        infl.push_back(t);
      end else begin
        m_ovf = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    io_issue_valid = 1'b0;
    io_rf_grant    = 1'b0;
    infl.delete();
    fifo.delete();
    m_ovf = 1'b0;
    #1;
    chk("rst_ready", 32'(io_issue_ready), 32'd1);
    chk("rst_wen", 32'(io_rf_wen), 32'd0);
    chk("rst_waddr", 32'(io_rf_waddr), 32'd0);
    chk("rst_wdata", 32'(io_rf_wdata), 32'd0);
    chk("rst_carry_wen", 32'(io_rf_carry_wen), 32'd0);
    chk("rst_carry", 32'(io_rf_carry), 32'd0);
    chk("rst_empty", 32'(io_empty), 32'd1);
    chk("rst_hit", 32'(io_query_hit), 32'd0);
    chk("rst_overflow", 32'(io_overflow), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic v; logic [10:0] rd; logic [3:0] f; logic cw;
    logic [15:0] alu; logic [31:0] mul; logic c; logic g; logic [10:0] rs;
    logic e_ready; logic e_wen; logic [10:0] e_waddr; logic [15:0] e_wdata;
    logic e_cwen; logic e_carry; logic e_hit; logic e_empty;
  } vec_t;
  vec_t vecs[9];
  logic rv;

  initial begin
    reset = 1'b0;
    io_issue_valid = 1'b0; io_issue_rd = 11'd0; io_issue_funct = 4'd0; io_issue_carry_wr = 1'b0;
    io_alu_out = 16'h0; io_alu_mul_out = 32'h0; io_alu_carry_out = 1'b0;
    io_rf_grant = 1'b0; io_query_rs = 11'd0;
    cyc = 0; wr_cnt = 0; acc_cnt = 0; m_ovf = 1'b0;

    //          v     rd      f     cw    alu       mul            c     g     rs     rdy   wen   waddr  wdata     cwen  carry hit   empty
    vecs[0] = '{1'b1, 11'd5,  4'd0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 11'd5, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 11'd0,  4'd0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 11'd5, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 11'd7,  4'd3, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 11'd5, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 11'd9, 4'd15, 1'b1, 16'h1234, 32'h00000000, 1'b0, 1'b1, 11'd5, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 11'd0,  4'd0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 11'd5, 1'b1, 1'b1, 11'd5, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 11'd0,  4'd0, 1'b0, 16'h5555, 32'hABCD1234, 1'b1, 1'b1, 11'd5, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 11'd0,  4'd0, 1'b0, 16'h0042, 32'h00000000, 1'b1, 1'b1, 11'd7, 1'b1, 1'b1, 11'd7, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 11'd0,  4'd0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 11'd9, 1'b1, 1'b1, 11'd9, 16'h0042, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 11'd0,  4'd0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 11'd9, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].rd, vecs[i].f, vecs[i].cw, vecs[i].alu, vecs[i].mul, vecs[i].c, vecs[i].g, vecs[i].rs);
      chk($sformatf("vec%0d_ready", i), 32'(io_issue_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_wen", i), 32'(io_rf_wen), 32'(vecs[i].e_wen));
      chk($sformatf("vec%0d_waddr", i), 32'(io_rf_waddr), 32'(vecs[i].e_waddr));
      chk($sformatf("vec%0d_wdata", i), 32'(io_rf_wdata), 32'(vecs[i].e_wdata));
      chk($sformatf("vec%0d_carry_wen", i), 32'(io_rf_carry_wen), 32'(vecs[i].e_cwen));
      chk($sformatf("vec%0d_carry", i), 32'(io_rf_carry), 32'(vecs[i].e_carry));
      chk($sformatf("vec%0d_hit", i), 32'(io_query_hit), 32'(vecs[i].e_hit));
      chk($sformatf("vec%0d_empty", i), 32'(io_empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_overflow", i), 32'(io_overflow), 32'd0);
    end

    // random traffic against the model, with occasional protocol violations
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_ready()) rv = ($urandom_range(0, 3) != 0);
      else           rv = ($urandom_range(0, 29) == 0);
      step(rv, 11'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0), 11'($urandom_range(0, 7)));
    end

    // backpressure: six accepted, then full; violation; ordered drain
    do_reset();
    acc_cnt = 0; wr_cnt = 0; wr_addrs.delete();
    for (int k = 0; k < 6; k++) step(1'b1, 11'(16 + k), 4'd0, 1'b0, 1'b0, 11'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 11'd0, 4'd0, 1'b0, 1'b0, 11'd16);
    chk("bp_accepted", 32'(acc_cnt), 32'd6);
    chk("bp_full_ready", 32'(io_issue_ready), 32'd0);
    chk("bp_no_overflow", 32'(io_overflow), 32'd0);
    step(1'b1, 11'd99, 4'd0, 1'b0, 1'b0, 11'd99);
    step(1'b0, 11'd0, 4'd0, 1'b0, 1'b0, 11'd99);
    chk("viol_overflow", 32'(io_overflow), 32'd1);
    chk("viol_dropped_hit", 32'(io_query_hit), 32'd0);
    for (int k = 0; k < 8; k++) step(1'b0, 11'd0, 4'd0, 1'b0, 1'b1, 11'd0);
    chk("bp_writes", 32'(wr_cnt), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < wr_addrs.size()) chk($sformatf("bp_order%0d", k), 32'(wr_addrs[k]), 32'(16 + k));
      else                     chk($sformatf("bp_order%0d", k), 32'hFFFF_FFFF, 32'(16 + k));
    end
    chk("viol_sticky", 32'(io_overflow), 32'd1);

    // reset with three tags in flight and two results buffered
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 11'(40 + k), 4'd0, 1'b0, 1'b0, 11'd40);
    chk("mid_hit_before", 32'(io_query_hit), 32'd1);
    chk("mid_wen_before", 32'(io_rf_wen), 32'd1);
    do_reset();
    wr_cnt = 0;
    for (int k = 0; k < 6; k++) step(1'b0, 11'd0, 4'd0, 1'b0, 1'b1, 11'(40 + k));
    chk("mid_no_write", 32'(wr_cnt), 32'd0);
    chk("mid_empty", 32'(io_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
